// File: rtl/bus_stream_writer_if.sv
// bus_stream_writer_if
//   Bundles the register-bus and output-stream signals of bus_stream_writer.
//   master: bus host / stream consumer side (drives strobes, address, data, sink_ready).
//   slave : the writer itself (drives readdata, sink_valid, sink_data).
//
//   chipselect  bus select; no access without it
//   address     2-bit register select
//   write/read  bus strobes
//   writedata   32-bit write data
//   readdata    32-bit registered read data
//   sink_valid  stream word present
//   sink_data   stream word (DATA_SIZE bits)
//   sink_ready  consumer accepts when high together with sink_valid
interface bus_stream_writer_if #(
    parameter int unsigned DATA_SIZE = 28
);
    logic                 chipselect;
    logic [1:0]           address;
    logic                 write;
    logic [31:0]          writedata;
    logic                 read;
    logic [31:0]          readdata;
    logic                 sink_valid;
    logic [DATA_SIZE-1:0] sink_data;
    logic                 sink_ready;

    modport master (
        output chipselect,
        output address,
        output write,
        output writedata,
        output read,
        input  readdata,
        input  sink_valid,
        input  sink_data,
        output sink_ready
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata,
        output sink_valid,
        output sink_data,
        input  sink_ready
    );
endinterface

// File: rtl/bus_stream_writer.sv
// bus_stream_writer
//   Bus-written FIFO feeding a valid/ready stream through one output holding register.
//   Registers (address):
//     0  W : push writedata[DATA_SIZE-1:0]; reads return 0
//     1  R : status {level @16, underrun @3, overflow @2, full @1, empty @0}
//        W : write-1-to-clear overflow (bit2) / underrun (bit3)
//     2  RW: control {threshold @16, irq_en @1, enable @0}
//     3  R : underrun_cnt (16 bits, saturating); any write clears it
//
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  bus_stream_writer_if.slave (register bus + output stream)
//     irq  registered level interrupt: irq_en && (level<threshold || overflow || underrun)
module bus_stream_writer #(
    parameter int unsigned DATA_SIZE = 28,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned LW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_stream_writer_if.slave    bus,
    output logic                  irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_UCNT   = 2'd3;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;

    // Output holding register
    logic                 out_valid;
    logic [DATA_SIZE-1:0] out_data;

    // Status / control state
    logic                 overflow;
    logic                 underrun;
    logic [15:0]          underrun_cnt;
    logic                 enable;
    logic                 irq_en;
    logic [LW-1:0]        threshold;
    logic [31:0]          readdata;

    // Decoded bus cycles
    logic wr_cycle;
    logic rd_cycle;
    logic push_req;
    logic push;
    logic pop;
    logic overflow_set;
    logic underrun_evt;
    logic fifo_empty;
    logic fifo_full;
    logic ovf_clr;
    logic und_clr;
    logic [31:0] rd_mux;

    assign wr_cycle   = bus.chipselect && bus.write;
    assign rd_cycle   = bus.chipselect && bus.read;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LEVEL_FULL);

    assign push_req     = wr_cycle && (bus.address == ADDR_DATA);
    // A push at full is dropped even if a pop frees a slot this same cycle.
    assign push         = push_req && !fifo_full;
    assign overflow_set = push_req && fifo_full;

    // Head moves to the output register when that register is free or draining.
    assign pop          = enable && !fifo_empty && (!out_valid || bus.sink_ready);
    // Consumer ready with nothing to take this cycle.
    assign underrun_evt = enable && bus.sink_ready && !out_valid;

    assign ovf_clr = wr_cycle && (bus.address == ADDR_STATUS) && bus.writedata[2];
    assign und_clr = wr_cycle && (bus.address == ADDR_STATUS) && bus.writedata[3];

    // Read data mux, sampled into readdata on a read cycle
    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            ADDR_DATA: rd_mux = '0;
            ADDR_STATUS: begin
                rd_mux[0]       = fifo_empty;
                rd_mux[1]       = fifo_full;
                rd_mux[2]       = overflow;
                rd_mux[3]       = underrun;
                rd_mux[16 +: LW] = level;
            end
            ADDR_CTRL: begin
                rd_mux[0]       = enable;
                rd_mux[1]       = irq_en;
                rd_mux[16 +: LW] = threshold;
            end
            ADDR_UCNT: rd_mux[15:0] = underrun_cnt;
            default:   rd_mux = '0;
        endcase
    end

    // FIFO array: no reset needed, contents are only observed through level-qualified pops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.writedata[DATA_SIZE-1:0];
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Output holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_ptr];
        end else if (out_valid && bus.sink_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky flags (set wins over W1C) and underrun counter
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            overflow <= overflow_set || (overflow && !ovf_clr);
            underrun <= underrun_evt || (underrun && !und_clr);
            if (wr_cycle && (bus.address == ADDR_UCNT)) begin
                underrun_cnt <= '0;
            end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    // Control register
    always_ff @(posedge clk) begin
        if (rst) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= '0;
        end else if (wr_cycle && (bus.address == ADDR_CTRL)) begin
            enable    <= bus.writedata[0];
            irq_en    <= bus.writedata[1];
            threshold <= bus.writedata[16 +: LW];
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_cycle) begin
                readdata <= rd_mux;
            end
            irq <= irq_en && ((level < threshold) || overflow || underrun);
        end
    end

    assign bus.readdata   = readdata;
    assign bus.sink_valid = out_valid;
    assign bus.sink_data  = out_data;

    // Upper writedata bits are don't-care for most registers.
    logic unused_writedata;
    assign unused_writedata = ^bus.writedata;

endmodule

// File: tb/tb_bus_stream_writer.sv
module tb_bus_stream_writer;

    localparam int unsigned DATA_SIZE = 28;
    localparam int unsigned DEPTH     = 512;
    localparam int unsigned LW        = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;

    always #5 clk = ~clk;

    bus_stream_writer_if #(.DATA_SIZE(DATA_SIZE)) bif ();

    bus_stream_writer #(
        .DATA_SIZE(DATA_SIZE),
        .DEPTH    (DEPTH),
        .LW       (LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave),
        .irq(irq)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [DATA_SIZE-1:0] q[$];
    logic                 m_valid;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_ovf;
    logic                 m_und;
    int unsigned          m_cnt;
    logic                 m_en;
    logic                 m_ien;
    int unsigned          m_thr;
    logic                 m_irq;
    logic [31:0]          m_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the specification's rules, applied to the inputs present at the edge.
    task automatic model_step();
        int unsigned lvl;
        logic pop, und_evt, irq_next, wr_cyc, rd_cyc, ovf_set;
        logic [31:0] wd;
        if (rst) begin
            q.delete();
            m_valid = 0; m_data = 0; m_ovf = 0; m_und = 0; m_cnt = 0;
            m_en = 0; m_ien = 0; m_thr = 0; m_irq = 0; m_rd = 0;
            return;
        end
        lvl      = q.size();
        wd       = bif.writedata;
        wr_cyc   = bif.chipselect && bif.write;
        rd_cyc   = bif.chipselect && bif.read;
        irq_next = m_ien && ((lvl < m_thr) || m_ovf || m_und);
        pop      = m_en && (lvl > 0) && (!m_valid || bif.sink_ready);
        und_evt  = m_en && bif.sink_ready && !m_valid;
        ovf_set  = 0;
        if (rd_cyc) begin
            case (bif.address)
                2'd0: m_rd = 0;
                2'd1: m_rd = (lvl << 16) | (32'(m_und) << 3) | (32'(m_ovf) << 2)
                           | (32'(lvl == DEPTH) << 1) | 32'(lvl == 0);
                2'd2: m_rd = (m_thr << 16) | (32'(m_ien) << 1) | 32'(m_en);
                default: m_rd = m_cnt;
            endcase
        end
        if (pop) begin
            m_data  = q.pop_front();
            m_valid = 1;
        end else if (m_valid && bif.sink_ready) begin
            m_valid = 0;
        end
        if (wr_cyc && bif.address == 2'd0) begin
            if (lvl < DEPTH) q.push_back(wd[DATA_SIZE-1:0]);
            else ovf_set = 1;
        end
        m_ovf = ovf_set || (m_ovf && !(wr_cyc && bif.address == 2'd1 && wd[2]));
        m_und = und_evt || (m_und && !(wr_cyc && bif.address == 2'd1 && wd[3]));
        if (wr_cyc && bif.address == 2'd3) m_cnt = 0;
        else if (und_evt && m_cnt < 65535) m_cnt++;
        if (wr_cyc && bif.address == 2'd2) begin
            m_en  = wd[0];
            m_ien = wd[1];
            m_thr = int'(wd[25:16]);
        end
        m_irq = irq_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("sink_valid", 64'(bif.sink_valid), 64'(m_valid));
        if (m_valid) check("sink_data", 64'(bif.sink_data), 64'(m_data));
        check("irq", 64'(irq), 64'(m_irq));
        check("readdata", 64'(bif.readdata), 64'(m_rd));
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bif.chipselect = 1; bif.write = 1; bif.address = addr; bif.writedata = data;
        tick();
        bif.chipselect = 0; bif.write = 0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bif.chipselect = 1; bif.read = 1; bif.address = addr;
        tick();
        data = bif.readdata;
        bif.chipselect = 0; bif.read = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    logic [31:0] rd;

    initial begin
        bif.chipselect = 0; bif.address = 0; bif.write = 0; bif.writedata = 0;
        bif.read = 0; bif.sink_ready = 0;

        // Reset state
        do_reset();
        check("rst_valid", 64'(bif.sink_valid), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        bus_read(2'd2, rd); check("rst_ctrl", 64'(rd), 64'd0);
        bus_read(2'd1, rd); check("rst_status", 64'(rd), 64'h1);
        bus_read(2'd3, rd); check("rst_ucnt", 64'(rd), 64'd0);

        // Back-to-back stream of three words
        bus_write(2'd0, 32'h1);
        bus_write(2'd0, 32'h2);
        bus_write(2'd0, 32'h3);
        bif.sink_ready = 1;
        bus_write(2'd2, 32'h1);
        tick(); check("seq_w0", 64'(bif.sink_data), 64'h1);
        tick(); check("seq_w1", 64'(bif.sink_data), 64'h2);
        tick(); check("seq_w2", 64'(bif.sink_data), 64'h3);
        tick(); check("seq_end_valid", 64'(bif.sink_valid), 64'd0);
        bif.sink_ready = 0;
        bus_write(2'd1, 32'hC);
        bus_write(2'd3, 32'h0);

        // Backpressure holds the word
        bus_write(2'd0, 32'hABC);
        bus_write(2'd0, 32'h123);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", 64'(bif.sink_data), 64'hABC);
            check("hold_valid", 64'(bif.sink_valid), 64'd1);
        end
        bus_read(2'd1, rd); check("hold_level", 64'(rd), 64'h0001_0000);
        bif.sink_ready = 1;
        tick(); check("drain_next", 64'(bif.sink_data), 64'h123);
        tick(); check("drain_empty", 64'(bif.sink_valid), 64'd0);
        bif.sink_ready = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            bif.sink_ready = 1'($urandom_range(0, 1));
            case (op)
                0, 1, 2, 3: bus_write(2'd0, $urandom);
                4: bus_read(2'($urandom_range(0, 3)), rd);
                5: bus_write(2'd1, 32'($urandom_range(0, 3)) << 2);
                6: bus_write(2'd2, (32'($urandom_range(0, 15)) << 16)
                                   | (32'($urandom_range(0, 1)) << 1)
                                   | 32'($urandom_range(0, 3) != 0));
                default: tick();
            endcase
        end
        bif.sink_ready = 0;

        // Overflow at full
        do_reset();
        for (int i = 0; i < 513; i++) bus_write(2'd0, $urandom);
        bus_read(2'd1, rd); check("full_status", 64'(rd), 64'h0200_0006);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, rd); check("ovf_cleared", 64'(rd), 64'h0200_0002);

        // Underrun counting
        do_reset();
        bus_write(2'd2, 32'h1);
        bif.sink_ready = 1;
        tick(); tick(); tick();
        bif.sink_ready = 0;
        bus_read(2'd1, rd); check("und_status", 64'(rd), 64'h9);
        bus_read(2'd3, rd); check("und_cnt3", 64'(rd), 64'd3);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd); check("und_cnt_clr", 64'(rd), 64'd0);

        // Threshold interrupt
        do_reset();
        bus_write(2'd0, 32'h11);
        bus_write(2'd0, 32'h22);
        bus_write(2'd0, 32'h33);
        bus_write(2'd2, (32'd4 << 16) | 32'h2);
        tick(); check("irq_below_thr", 64'(irq), 64'd1);
        bus_write(2'd0, 32'h44);
        tick(); check("irq_at_thr", 64'(irq), 64'd0);

        // Reset mid-transfer
        do_reset();
        bus_write(2'd2, (32'd16 << 16) | 32'h3);
        for (int i = 0; i < 11; i++) bus_write(2'd0, 32'(i + 100));
        bus_read(2'd1, rd); check("pre_rst_level", 64'(rd), 64'h000A_0000);
        check("pre_rst_valid", 64'(bif.sink_valid), 64'd1);
        check("pre_rst_irq", 64'(irq), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        check("post_rst_valid", 64'(bif.sink_valid), 64'd0);
        check("post_rst_irq", 64'(irq), 64'd0);
        bus_read(2'd2, rd); check("post_rst_ctrl", 64'(rd), 64'd0);
        bus_read(2'd1, rd); check("post_rst_status", 64'(rd), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
